hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline sequencing controller for the 5-stage RV32I core (IF, ID, EX, MEM, WB). It sits beside the decode stage and consumes its per-instruction register and control fields. It keeps a shadow copy of the destination registers of the instructions in EX and MEM. From that state it generates stall, flush and forwarding selects, and it sequences data-memory wait states with a timeout watchdog.

## Interface
- MEM_TIMEOUT, 16: maximum number of consecutive un-acknowledged dmem_req cycles before the error state.
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  5  source register indices from decode.
- id_use_rs1, id_use_rs2  in  1  the instruction reads rs1 / rs2.
- id_rd  in  5  destination index from decode; decode already forces 0 for branches.
- id_write_reg  in  1  decode write_reg.
- id_is_load  in  1  instruction is lb/lh/lw/lbu/lhu.
- ex_redirect  in  1  EX resolved a taken branch, jal or jalr.
- dmem_req  in  1  MEM stage issues a load or store.
- dmem_ready  in  1  data memory accepts / returns this cycle.
- stall_if, stall_id  out  1  hold PC and the IF/ID register.
- flush_if  out  1  clear the IF/ID register to a bubble.
- flush_ex  out  1  load a bubble into the ID/EX register.
- stall_mem  out  1  freeze the EX/MEM and MEM/WB registers and all upstream stages.
- fwd_a, fwd_b  out  2  operand select for rs1 / rs2: 00 = register file, 01 = EX result, 10 = MEM result.
- mem_err  out  1  sticky data-memory timeout.
- stall_cycles  out  32  saturating count of cycles in which stall_id = 1.

## Operation
- Shadow registers:
  - ex_rd[4:0], ex_wr, ex_ld track the instruction in EX.
  - mem_rd[4:0], mem_wr track the instruction in MEM.
  - All reset to 0.
- Shadow advance: on every clk edge with stall_mem = 0:
  - mem_* <= ex_*.
  - If flush_ex = 1 or id_valid = 0: ex_* <= 0.
  - Otherwise: ex_rd <= id_rd, ex_wr <= id_write_reg & (id_rd != 0), ex_ld <= id_is_load.
  - When stall_mem = 1, all shadow registers hold.
- hit1 = id_use_rs1 & (id_rs1 == ex_rd) & ex_wr. hit2 is the same for rs2.
- load_use = id_valid & ex_ld & ex_wr & (hit1 | hit2).
- Output priority, highest first:
  - stall_mem = 1: stall_if = stall_id = 1, flush_if = flush_ex = 0. An ex_redirect arriving now is held by the frozen EX stage and takes effect in the first cycle with stall_mem = 0.
  - ex_redirect = 1: flush_if = flush_ex = 1, stall_if = stall_id = 0. Any load_use is ignored because the instruction in ID is killed.
  - load_use = 1: stall_if = stall_id = 1, flush_ex = 1, flush_if = 0.
  - Otherwise all four outputs are 0.
- Forwarding, per operand; shown for rs1, rs2 identical:
  - 01 if hit1 and ex_ld = 0.
  - Else 10 if id_use_rs1 & mem_wr & (id_rs1 == mem_rd).
  - Else 00.
  - Index 0 never forwards. The WB stage is covered by register-file write-through.
- Memory FSM, states M_IDLE, M_WAIT, M_ERR, with counter cnt (width $clog2(MEM_TIMEOUT+1)):
  - M_IDLE: if dmem_req & !dmem_ready, go to M_WAIT with cnt <= 1. Otherwise stay, cnt <= 0.
  - M_WAIT: if dmem_ready, go to M_IDLE with cnt <= 0. Else if cnt == MEM_TIMEOUT, go to M_ERR. Else cnt <= cnt + 1.
  - M_ERR: terminal until rst. mem_err = 1; stall_mem = 1 regardless of inputs.
  - In M_IDLE and M_WAIT: stall_mem = dmem_req & !dmem_ready.
- stall_cycles: increments on every edge with stall_id = 1 and saturates at 32'hFFFF_FFFF.

## Timing
- While rst = 1, all outputs are 0: shadow registers, cnt, stall_cycles and mem_err are cleared, the FSM is in M_IDLE, and the combinational outputs are gated to 0.
- Reset asserted mid-wait returns the FSM to M_IDLE immediately; deassertion resumes at the next edge.
- Stall, flush and forward outputs are combinational from the inputs and shadow state, with zero-cycle latency, so they are valid in the same cycle.
- Load-use inserts exactly one bubble. In the next cycle ex_ld = 0, so the dependency resolves through the 10 (MEM) forward.
- dmem_ready in the same cycle as dmem_req gives zero wait states.
- mem_err rises at the edge after MEM_TIMEOUT+1 consecutive not-ready request cycles.

## Test plan
- Back-to-back dependency: add x5 then add x6,x5,x1, no stalls -> fwd_a = 01 in the second instruction's ID cycle. An instruction two behind reading x5 -> fwd_a = 10.
- Load-use: lw x7 then add x8,x7,x7 -> one cycle with stall_if = stall_id = flush_ex = 1; the next cycle gives fwd_a = fwd_b = 10 and stall_cycles = 1.
- Redirect plus load-use in the same cycle -> flush_if = flush_ex = 1, stall_id = 0; the next cycle shows ex_wr = 0 and no forwarding.
- dmem_req with dmem_ready low for 3 cycles while ex_redirect = 1 -> stall_mem = 1 and flush outputs = 0 for 3 cycles; on the ready cycle flush_if = 1.
- MEM_TIMEOUT = 16, dmem_ready held low -> mem_err = 0 through 17 request cycles, 1 after the 17th edge. It stays 1 when ready returns; rst clears it.
- Writes to x0 (id_rd = 0, id_write_reg = 1) followed by a read of x0 -> fwd = 00 and no stall, even for an lw to x0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core: stall/flush/forward selects plus dmem wait-state watchdog.
// Latency: stall, flush and forward outputs are combinational (same cycle); shadow state, FSM and counters update on clk.
// Backpressure: stall_mem (dmem not ready, or timeout error) freezes everything and outranks redirect and load-use.
//
// Ports:
//   clk, rst                    core clock, asynchronous active-high reset
//   id_*                        decode-stage instruction fields (valid, rs1/rs2 + use flags, rd, write_reg, is_load)
//   ex_redirect                 taken branch / jal / jalr resolved in EX
//   dmem_req, dmem_ready        MEM-stage data memory handshake
//   stall_if, stall_id          hold PC and IF/ID
//   flush_if, flush_ex          bubble into IF/ID, ID/EX
//   stall_mem                   freeze EX/MEM, MEM/WB and everything upstream
//   fwd_a, fwd_b                operand select: 00 regfile, 01 EX result, 10 MEM result
//   mem_err                     sticky data-memory timeout
//   stall_cycles                saturating count of stall_id cycles
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_write_reg,
    input  logic        id_is_load,
    input  logic        ex_redirect,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        stall_if,
    output logic        stall_id,
    output logic        flush_if,
    output logic        flush_ex,
    output logic        stall_mem,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        mem_err,
    output logic [31:0] stall_cycles
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {M_IDLE, M_WAIT, M_ERR} mstate_t;

    mstate_t        mstate;
    logic [CW-1:0]  cnt;

    // Shadow copy of the destinations held by the EX and MEM stages.
    logic [4:0] ex_rd;
    logic       ex_wr;
    logic       ex_ld;
    logic [4:0] mem_rd;
    logic       mem_wr;

    logic hit1, hit2, load_use, stall_mem_raw;

    always_comb begin
        stall_mem_raw = (mstate == M_ERR) | (dmem_req & ~dmem_ready);
        // ex_wr is never set for rd = x0, so x0 can never produce a hit.
        hit1     = id_use_rs1 & (id_rs1 == ex_rd) & ex_wr;
        hit2     = id_use_rs2 & (id_rs2 == ex_rd) & ex_wr;
        load_use = id_valid & ex_ld & ex_wr & (hit1 | hit2);

        stall_if  = 1'b0;
        stall_id  = 1'b0;
        flush_if  = 1'b0;
        flush_ex  = 1'b0;
        stall_mem = 1'b0;
        fwd_a     = 2'b00;
        fwd_b     = 2'b00;

        if (!rst) begin
            stall_mem = stall_mem_raw;
            if (stall_mem_raw) begin
                // A redirect seen now stays parked in the frozen EX stage.
                stall_if = 1'b1;
                stall_id = 1'b1;
            end else if (ex_redirect) begin
                // The ID instruction is being killed, so its load-use is moot.
                flush_if = 1'b1;
                flush_ex = 1'b1;
            end else if (load_use) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
                flush_ex = 1'b1;
            end

            // A load in EX has no result yet; after the bubble it is caught from MEM.
            if (hit1 && !ex_ld)
                fwd_a = 2'b01;
            else if (id_use_rs1 && mem_wr && (id_rs1 == mem_rd))
                fwd_a = 2'b10;

            if (hit2 && !ex_ld)
                fwd_b = 2'b01;
            else if (id_use_rs2 && mem_wr && (id_rs2 == mem_rd))
                fwd_b = 2'b10;
        end
    end

    assign mem_err = ~rst & (mstate == M_ERR);

    // Shadow pipeline advance; holds whenever the memory stage is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_rd  <= 5'd0;
            ex_wr  <= 1'b0;
            ex_ld  <= 1'b0;
            mem_rd <= 5'd0;
            mem_wr <= 1'b0;
        end else if (!stall_mem) begin
            mem_rd <= ex_rd;
            mem_wr <= ex_wr;
            if (flush_ex || !id_valid) begin
                ex_rd <= 5'd0;
                ex_wr <= 1'b0;
                ex_ld <= 1'b0;
            end else begin
                ex_rd <= id_rd;
                ex_wr <= id_write_reg & (id_rd != 5'd0);
                ex_ld <= id_is_load;
            end
        end
    end

    // Data-memory wait-state sequencer with timeout watchdog.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstate <= M_IDLE;
            cnt    <= '0;
        end else begin
            case (mstate)
                M_IDLE: begin
                    if (dmem_req && !dmem_ready) begin
                        mstate <= M_WAIT;
                        cnt    <= CW'(1);
                    end else begin
                        cnt    <= '0;
                    end
                end
                M_WAIT: begin
                    if (dmem_ready) begin
                        mstate <= M_IDLE;
                        cnt    <= '0;
                    end else if (cnt == CW'(MEM_TIMEOUT)) begin
                        mstate <= M_ERR;
                    end else begin
                        cnt    <= cnt + CW'(1);
                    end
                end
                M_ERR: begin
                    mstate <= M_ERR;
                end
                default: begin
                    mstate <= M_IDLE;
                    cnt    <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cycles <= 32'd0;
        else if (stall_id && (stall_cycles != 32'hFFFF_FFFF))
            stall_cycles <= stall_cycles + 32'd1;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, redirect, memory wait states and timeout.
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
// Each check is an immediate assertion that counts and reports failures.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2, id_write_reg, id_is_load;
    logic        ex_redirect, dmem_req, dmem_ready;
    logic        stall_if, stall_id, flush_if, flush_ex, stall_mem, mem_err;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] stall_cycles;

    int errors = 0;
    int checks = 0;

    hazard_ctrl #(.MEM_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_write_reg(id_write_reg), .id_is_load(id_is_load),
        .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .stall_if(stall_if), .stall_id(stall_id), .flush_if(flush_if), .flush_ex(flush_ex),
        .stall_mem(stall_mem), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .mem_err(mem_err), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Drive the decode fields in one go.
    task automatic id_set(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic wr, input logic ld);
        id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        id_rd = rd; id_write_reg = wr; id_is_load = ld;
    endtask

    task automatic ctl4(input string tag, input logic sif, input logic sid,
                        input logic fif, input logic fex);
        chk({tag, ".stall_if"}, {31'd0, stall_if}, {31'd0, sif});
        chk({tag, ".stall_id"}, {31'd0, stall_id}, {31'd0, sid});
        chk({tag, ".flush_if"}, {31'd0, flush_if}, {31'd0, fif});
        chk({tag, ".flush_ex"}, {31'd0, flush_ex}, {31'd0, fex});
    endtask

    task automatic fwd(input string tag, input logic [1:0] a, input logic [1:0] b);
        chk({tag, ".fwd_a"}, {30'd0, fwd_a}, {30'd0, a});
        chk({tag, ".fwd_b"}, {30'd0, fwd_b}, {30'd0, b});
    endtask

    initial begin
        rst = 1'b1;
        id_set(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1);
        ex_redirect = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;

        // Reset: everything gated to zero even with active inputs.
        next();
        ctl4("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst.stall_mem", {31'd0, stall_mem}, 32'd0);
        chk("rst.mem_err", {31'd0, mem_err}, 32'd0);
        chk("rst.stall_cycles", stall_cycles, 32'd0);
        fwd("rst", 2'b00, 2'b00);

        rst = 1'b0; ex_redirect = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;

        // add x5,x1,x2
        id_set(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
        settle();
        ctl4("add5", 1'b0, 1'b0, 1'b0, 1'b0);
        fwd("add5", 2'b00, 2'b00);
        next();
        // add x6,x5,x1 : x5 in EX
        id_set(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
        settle();
        fwd("b2b", 2'b01, 2'b00);
        chk("b2b.stall_id", {31'd0, stall_id}, 32'd0);
        next();
        // add x7,x6,x5 : x6 in EX, x5 in MEM
        id_set(1'b1, 5'd6, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0);
        settle();
        fwd("ex_mem", 2'b01, 2'b10);
        next();
        // bubble
        id_set(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        next();
        // x7 now in MEM, EX empty; rs2 matches but is not used
        id_set(1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0);
        settle();
        fwd("mem_only", 2'b10, 2'b00);
        next();

        // lw x7,0(x2)
        id_set(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        settle();
        ctl4("lw7", 1'b0, 1'b0, 1'b0, 1'b0);
        next();
        // add x8,x7,x7 : load-use
        id_set(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
        settle();
        ctl4("lu", 1'b1, 1'b1, 1'b0, 1'b1);
        fwd("lu", 2'b00, 2'b00);
        next();
        settle();
        ctl4("lu_after", 1'b0, 1'b0, 1'b0, 1'b0);
        fwd("lu_after", 2'b10, 2'b10);
        chk("lu_after.stall_cycles", stall_cycles, 32'd1);
        next();

        // lw x9 then redirect in the same cycle as the dependent instruction
        id_set(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
        next();
        id_set(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
        ex_redirect = 1'b1;
        settle();
        ctl4("redir_lu", 1'b0, 1'b0, 1'b1, 1'b1);
        next();
        ex_redirect = 1'b0;
        id_set(1'b1, 5'd10, 1'b1, 5'd10, 1'b1, 5'd11, 1'b1, 1'b0);
        settle();
        chk("redir_after.ex_wr", {31'd0, dut.ex_wr}, 32'd0);
        fwd("redir_after", 2'b00, 2'b00);
        chk("redir_after.stall_cycles", stall_cycles, 32'd1);
        id_set(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        next();
        next();

        // lw x0 then read x0: no stall, no forward
        id_set(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        next();
        id_set(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
        settle();
        ctl4("x0_ex", 1'b0, 1'b0, 1'b0, 1'b0);
        fwd("x0_ex", 2'b00, 2'b00);
        next();
        settle();
        fwd("x0_mem", 2'b00, 2'b00);

        // Put x12 in EX, then wait states with a pending redirect
        id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0);
        next();
        id_set(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0);
        ex_redirect = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk($sformatf("wait%0d.stall_mem", i), {31'd0, stall_mem}, 32'd1);
            ctl4($sformatf("wait%0d", i), 1'b1, 1'b1, 1'b0, 1'b0);
            next();
        end
        dmem_ready = 1'b1;
        settle();
        chk("ready.stall_mem", {31'd0, stall_mem}, 32'd0);
        ctl4("ready", 1'b0, 1'b0, 1'b1, 1'b1);
        fwd("ready", 2'b01, 2'b00);
        chk("ready.stall_cycles", stall_cycles, 32'd4);
        next();
        ex_redirect = 1'b0;
        id_set(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        settle();
        chk("zero_ws.stall_mem", {31'd0, stall_mem}, 32'd0);
        next();

        // Timeout: 17 not-ready request cycles
        dmem_ready = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            settle();
            chk($sformatf("to%0d.mem_err", i), {31'd0, mem_err}, 32'd0);
            next();
        end
        settle();
        chk("to_err.mem_err", {31'd0, mem_err}, 32'd1);
        chk("to_err.stall_mem", {31'd0, stall_mem}, 32'd1);
        chk("to_err.stall_cycles", stall_cycles, 32'd21);
        dmem_req = 1'b0; dmem_ready = 1'b1;
        settle();
        chk("err_sticky.stall_mem", {31'd0, stall_mem}, 32'd1);
        chk("err_sticky.stall_id", {31'd0, stall_id}, 32'd1);
        next();
        chk("err_sticky.mem_err", {31'd0, mem_err}, 32'd1);
        chk("err_sticky.stall_cycles", stall_cycles, 32'd22);

        // Asynchronous reset clears the error immediately
        rst = 1'b1;
        settle();
        chk("arst.mem_err", {31'd0, mem_err}, 32'd0);
        chk("arst.stall_mem", {31'd0, stall_mem}, 32'd0);
        chk("arst.stall_cycles", stall_cycles, 32'd0);
        next();
        rst = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
        settle();
        chk("post_rst.mem_err", {31'd0, mem_err}, 32'd0);

        // Reset mid-wait must clear the watchdog count
        dmem_req = 1'b1;
        for (int i = 0; i < 5; i++) next();
        rst = 1'b1;
        next();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) next();
        chk("midrst16.mem_err", {31'd0, mem_err}, 32'd0);
        next();
        chk("midrst17.mem_err", {31'd0, mem_err}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
